adc_axis_packetizer: RTL

ADC_AXIS_PACKETIZER -- requirements
Module: adc_axis_packetizer

---
 rtl/rfsoc_config.sv | 27 ++
 rtl/axis_sync_fifo.sv | 55 +++++
 rtl/adc_axis_packetizer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/rfsoc_config.sv
// rfsoc_config: shared constants for the RFSoC control path.
//   sdata            - gpio_ctrl bit carrying the serial config data
//   adc_pkt_len_clk  - gpio_ctrl bit used as the serial config clock
//   config_reg_width - width of the packet-length config register
//   adc_hdr_tag      - upper 16 bits of every packet header word
//   pkt_state_e      - packetizer FSM states
//   clamp_pkt_len    - maps a zero length onto one word
package rfsoc_config;

  localparam int unsigned sdata            = 0;
  localparam int unsigned adc_pkt_len_clk  = 12;
  localparam int unsigned config_reg_width = 16;
  localparam logic [15:0] adc_hdr_tag      = 16'hADC0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } pkt_state_e;

  function automatic logic [config_reg_width-1:0] clamp_pkt_len(
    input logic [config_reg_width-1:0] len
  );
    return (len == '0) ? config_reg_width'(1) : len;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: single-clock FIFO with registered pointers.
//   clk, rst_n        - clock, asynchronous active-low reset (empties FIFO)
//   wr_en, wr_data    - write request; accepted when not full, or when full
//                       and a read happens in the same cycle
//   rd_en, rd_data    - read request (ignored when empty); rd_data is the head
//   full, empty       - status flags derived from the pointers
module axis_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the
  // address bits match.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_wr;
  logic        do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/adc_axis_packetizer.sv
// adc_axis_packetizer: buffers ADC samples and emits them to the PS DMA as
// packets of one header word ({16'hADC0, seq_num}) followed by pkt_len words.
//   ps_clk                 - sole clock (rising edge)
//   rst                    - asynchronous active-low reset
//   gpio_ctrl              - control bus; bit sdata = serial data,
//                            bit adc_pkt_len_clk = serial config clock
//   select_in              - enables serial loading of the packet length
//   s_axis_*               - sample stream in (tready = FIFO not full)
//   m_axis_*               - packetized stream out, tlast on final data word
//   overflow               - sticky, set when a sample is offered while full
module adc_axis_packetizer
  import rfsoc_config::*;
#(
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned DEFAULT_PKT_LEN = 16
) (
  input  logic        ps_clk,
  input  logic        rst,
  input  logic [15:0] gpio_ctrl,
  input  logic        select_in,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        overflow
);

  localparam logic [config_reg_width-1:0] DEF_LEN = config_reg_width'(DEFAULT_PKT_LEN);

  pkt_state_e state;
  pkt_state_e state_nxt;

  logic        ready_en;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_wr;
  logic        fifo_rd;
  logic [31:0] fifo_head;

  logic                        len_clk_d;
  logic                        len_clk_rise;
  logic [config_reg_width-1:0] pkt_len_sr;
  logic [config_reg_width-1:0] pkt_len_act;
  logic [config_reg_width-1:0] word_cnt;
  logic [15:0]                 seq_num;

  logic load_len;
  logic clr_cnt;
  logic inc_cnt;
  logic inc_seq;

  // Only the serial data and clock bits are consumed from the control bus.
  logic unused_gpio;
  assign unused_gpio = ^gpio_ctrl;

  // ---------------------------------------------------------------- input
  // tready is held low during reset and rises on the first edge after it.
  always_ff @(posedge ps_clk or negedge rst) begin
    if (!rst) ready_en <= 1'b0;
    else      ready_en <= 1'b1;
  end

  assign s_axis_tready = ready_en & ~fifo_full;
  assign fifo_wr       = s_axis_tvalid & s_axis_tready;

  always_ff @(posedge ps_clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (s_axis_tvalid && fifo_full) begin
      overflow <= 1'b1;
    end
  end

  axis_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (ps_clk),
    .rst_n   (rst),
    .wr_en   (fifo_wr),
    .wr_data (s_axis_tdata),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // -------------------------------------------------------- serial config
  assign len_clk_rise = gpio_ctrl[adc_pkt_len_clk] & ~len_clk_d;

  always_ff @(posedge ps_clk or negedge rst) begin
    if (!rst) begin
      len_clk_d  <= 1'b0;
      pkt_len_sr <= DEF_LEN;
    end else begin
      len_clk_d <= gpio_ctrl[adc_pkt_len_clk];
      if (len_clk_rise && select_in) begin
        pkt_len_sr <= {gpio_ctrl[sdata], pkt_len_sr[config_reg_width-1:1]};
      end
    end
  end

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge ps_clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    fifo_rd       = 1'b0;
    load_len      = 1'b0;
    clr_cnt       = 1'b0;
    inc_cnt       = 1'b0;
    inc_seq       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          load_len  = 1'b1;
          state_nxt = ST_HEADER;
        end
      end
      ST_HEADER: begin
        m_axis_tdata  = {adc_hdr_tag, seq_num};
        m_axis_tvalid = 1'b1;
        if (m_axis_tready) begin
          clr_cnt   = 1'b1;
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        m_axis_tdata  = fifo_head;
        m_axis_tvalid = ~fifo_empty;
        m_axis_tlast  = (word_cnt == pkt_len_act - 1'b1);
        if (!fifo_empty && m_axis_tready) begin
          fifo_rd = 1'b1;
          inc_cnt = 1'b1;
          if (m_axis_tlast) begin
            inc_seq   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------ packet counters
  // pkt_len_act is sampled only on IDLE->HEADER so a config change made
  // mid-packet takes effect with the following packet.
  always_ff @(posedge ps_clk or negedge rst) begin
    if (!rst) begin
      pkt_len_act <= DEF_LEN;
      word_cnt    <= '0;
      seq_num     <= '0;
    end else begin
      if (load_len) pkt_len_act <= clamp_pkt_len(pkt_len_sr);
      if (clr_cnt)      word_cnt <= '0;
      else if (inc_cnt) word_cnt <= word_cnt + 1'b1;
      if (inc_seq) seq_num <= seq_num + 16'd1;
    end
  end

endmodule
